spi_master_param_driver: RTL
============================

// Module: spi_master_param_driver
// PURPOSE
// - Parametrised successor of the 8-bit SPI master driver: generic word width,
//   programmable SCLK divider, all four SPI modes (CPOL/CPHA), N chip selects.
// - Sits between the AMBA-side register logic (start/data/busy) and the SPI pins;
//   pairs with spi_slave_driver on the same bus in the loopback bench.
// PARAMETERS
// - DATA_W   8  bits per transfer (>=2)
// - CLK_DIV  2  clk_i cycles per SCLK half-period (>=1)
// - CS_N     1  number of chip-select lines (>=1)
// PORTS
// - clk_i        in   1                 system clock, all logic on rising edge
// - rst_i        in   1                 synchronous, active-high reset
// - start_i      in   1                 level request; launches a transfer when idle
// - cpol_i       in   1                 SCLK idle level, latched at launch
// - cpha_i       in   1                 0: sample leading edge, 1: sample trailing edge; latched
// - cs_sel_i     in   $clog2(CS_N)|1    chip-select index, latched at launch
// - data_in_bi   in   DATA_W            TX word, latched at launch
// - busy_o       out  1                 high from launch until return to IDLE
// - done_o       out  1                 1-cycle pulse when data_out_bo updates
// - data_out_bo  out  DATA_W            last received word, held until next done_o
// - spi_miso_i   in   1                 serial data from slave
// - spi_mosi_o   out  1                 serial data to slave
// - spi_sclk_o   out  1                 serial clock
// - spi_cs_bo    out  CS_N              active-low chip selects, one-hot-low when active
// BEHAVIOUR
// - Reset: FSM=IDLE, busy_o=0, done_o=0, data_out_bo=0, spi_mosi_o=0,
//   spi_sclk_o=0, spi_cs_bo=all 1s; takes effect mid-transfer too (abort, no done_o).
// - FSM IDLE -> SETUP -> XFER -> HOLD -> IDLE; all outputs registered.
// - IDLE: spi_sclk_o = registered cpol_i; if start_i=1 on edge N, latch cpol/cpha/
//   cs_sel/data_in, busy_o=1 and cs_bo[cs_sel]=0 from N+1, enter SETUP.
// - SETUP: CLK_DIV cycles; first MOSI bit valid on entry (both CPHA values).
// - XFER: 2*DATA_W SCLK edges, one every CLK_DIV cycles, first toggling SCLK
//   away from CPOL. CPHA=0: sample MISO on odd (leading) edges, shift MOSI on even
//   edges except the last. CPHA=1: shift MOSI on leading edges, sample on trailing.
// - HOLD: CLK_DIV cycles, SCLK at CPOL, CS still low; on exit CS high, busy_o=0,
//   done_o=1, data_out_bo=received word, same cycle.
// - busy duration = (2*DATA_W+2)*CLK_DIV cycles; DATA_W=8, CLK_DIV=2 -> 36.
// - IDLE lasts >=1 cycle with CS high between transfers; start_i held high
//   gives back-to-back transfers separated by exactly one idle cycle.
// - start_i and all config inputs ignored while busy_o=1; cs_sel_i >= CS_N
//   selects no line (transfer runs, all CS stay high).
// - Bit order MSB first; bit counter $clog2(DATA_W)+1 wide, no wrap in a word.
// CONFIGURATION
// - SPI_MASTER_LSB_FIRST_EN defined: TX and RX bit order LSB first (bit 0 first
//   on MOSI, first MISO sample lands in data_out_bo[0]).
// - Undefined: MSB first only. Timing identical either way.
// TESTING
// - Loopback MISO=MOSI, mode 0, data_in=0x35, start 1 cycle -> done_o at busy
//   cycle 36, data_out_bo=0x35, SCLK 8 rising edges, CS[0] low 36 cycles.
// - spi_slave_driver attached, s_data=0xA3, m_data=0x35 -> master gets 0xA3,
//   slave gets 0x35; then swap words and repeat -> master 0x35, slave 0xA3.
// - Modes 1,2,3 loopback with 0x96 -> data_out 0x96, SCLK idle = CPOL,
//   sample edge per CPHA checked against MOSI transitions.
// - CS_N=4, cs_sel_i=2 -> only spi_cs_bo[2] low; cs_sel_i changed mid-transfer
//   and start_i pulsed while busy -> no effect.
// - rst_i asserted at busy cycle 10 -> next cycle all outputs at reset values,
//   no done_o; start held high through reset -> transfer launches 1 cycle after
//   rst_i falls.
// - SPI_MASTER_LSB_FIRST_EN, data_in=0x01 -> first MOSI bit 1; loopback 0x01 back.

Source files
------------

// File: rtl/spi_master_param_driver.sv
// Parametrised SPI master: DATA_W-bit words, CLK_DIV clocks per SCLK half-period, all four modes, CS_N selects.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first TX/RX order; the default build is MSB first.
//
// state | meaning
// IDLE  | CS high, SCLK follows cpol_i, waits for start_i
// SETUP | CS low, first MOSI bit driven, CLK_DIV cycles before the first SCLK edge
// XFER  | 2*DATA_W SCLK edges, one every CLK_DIV cycles
// HOLD  | SCLK parked at CPOL, CS still low for CLK_DIV cycles, then done
module spi_master_param_driver #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2,
    parameter int CS_N    = 1
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     start_i,
    input  logic                                     cpol_i,
    input  logic                                     cpha_i,
    input  logic [((CS_N > 1) ? $clog2(CS_N) : 1)-1:0] cs_sel_i,
    input  logic [DATA_W-1:0]                        data_in_bi,
    output logic                                     busy_o,
    output logic                                     done_o,
    output logic [DATA_W-1:0]                        data_out_bo,
    input  logic                                     spi_miso_i,
    output logic                                     spi_mosi_o,
    output logic                                     spi_sclk_o,
    output logic [CS_N-1:0]                          spi_cs_bo
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BC_W  = $clog2(DATA_W) + 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(DATA_W - 1);
`ifdef SPI_MASTER_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
    state_t state, state_nxt;

    logic [DIV_W-1:0]  div_cnt;
    logic [BC_W-1:0]   bit_cnt;
    logic [DATA_W-1:0] tx_sr, rx_sr;
    logic              cpol_q, cpha_q;
    logic [CS_N-1:0]   cs_dec;
    logic              tick, launch, finish, leading, sample_en, shift_en;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Leading edge = SCLK currently at its idle level and about to leave it.
    always_comb begin
        state_nxt = state;
        tick      = (div_cnt == '0);
        leading   = (spi_sclk_o == cpol_q);
        launch    = 1'b0;
        finish    = 1'b0;
        sample_en = 1'b0;
        shift_en  = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    launch    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (tick) state_nxt = XFER;
            end
            XFER: begin
                if (tick) begin
                    sample_en = cpha_q ? !leading : leading;
                    shift_en  = cpha_q ? (leading && bit_cnt != '0)
                                       : (!leading && bit_cnt != LAST_BIT);
                    if (!leading && bit_cnt == LAST_BIT) state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (tick) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Out-of-range selects leave every line high.
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < CS_N; i++) begin
            if (int'(cs_sel_i) == i) cs_dec[i] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            data_out_bo <= '0;
            spi_mosi_o  <= 1'b0;
            spi_sclk_o  <= 1'b0;
            spi_cs_bo   <= '1;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (state == IDLE) begin
                spi_sclk_o <= cpol_i;
                if (launch) begin
                    cpol_q     <= cpol_i;
                    cpha_q     <= cpha_i;
                    tx_sr      <= data_in_bi;
                    spi_mosi_o <= LSB_FIRST ? data_in_bi[0] : data_in_bi[DATA_W-1];
                    busy_o     <= 1'b1;
                    spi_cs_bo  <= cs_dec;
                    div_cnt    <= DIV_LOAD;
                    bit_cnt    <= '0;
                end
            end else begin
                div_cnt <= tick ? DIV_LOAD : div_cnt - DIV_W'(1);
                if (state == XFER && tick) begin
                    spi_sclk_o <= ~spi_sclk_o;
                    if (!leading) bit_cnt <= bit_cnt + BC_W'(1);
                end
                if (sample_en) begin
                    rx_sr <= LSB_FIRST ? {spi_miso_i, rx_sr[DATA_W-1:1]}
                                       : {rx_sr[DATA_W-2:0], spi_miso_i};
                end
                if (shift_en) begin
                    tx_sr      <= LSB_FIRST ? (tx_sr >> 1) : (tx_sr << 1);
                    spi_mosi_o <= LSB_FIRST ? tx_sr[1] : tx_sr[DATA_W-2];
                end
                if (finish) begin
                    busy_o      <= 1'b0;
                    done_o      <= 1'b1;
                    data_out_bo <= rx_sr;
                    spi_cs_bo   <= '1;
                end
            end
        end
    end

endmodule
